// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard
//   Owns the single write port of the 32x32 register file. The in-order
//   writeback stage (WB) and the variable-latency multi-cycle unit (MC) share
//   the port with WB at fixed priority. A per-register busy scoreboard tracks
//   MC destinations still in flight, and decode is held on RAW/WAW hazards
//   against them, when the MC unit is full, or while an MC result is starving.
//
// Ports
//   clock, reset                    clock; synchronous active-high reset
//   id_valid, id_rs1, id_rs2,       decode-stage instruction
//   id_rd, id_rd_wen, id_is_mc
//   issue_stall                     hold decode this cycle
//   wb_valid, wb_rd, wb_data        pipeline writeback request
//   mc_valid, mc_rd, mc_data        MC result request
//   mc_ready                        MC result accepted (valid & ready = transfer)
//   rf_wen, rf_write_reg,           register file write port
//   rf_write_data
//   busy_vec                        bit i set = register i awaits an MC result
//
// State
//   register    | meaning
//   ------------+-------------------------------------------------------------
//   busy        | per-register "MC result pending" flags, bit 0 tied low
//   outstanding | MC ops issued and not yet transferred back
//   wait_rem    | refused-cycle budget left before starvation (down-counter)
//   starve      | MC result refused too long; decode held until it transfers

module regfile_wb_scoreboard #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int MAX_WAIT        = 8
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_rd_wen,
   input  logic        id_is_mc,
   output logic        issue_stall,

   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,

   input  logic        mc_valid,
   input  logic [4:0]  mc_rd,
   input  logic [31:0] mc_data,
   output logic        mc_ready,

   output logic        rf_wen,
   output logic [4:0]  rf_write_reg,
   output logic [31:0] rf_write_data,

   output logic [31:0] busy_vec
);

   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);

   logic [31:0]       busy;
   logic [OUT_W-1:0]  outstanding;
   logic [WAIT_W-1:0] wait_rem;
   logic              starve;

   logic              wb_eff;
   logic              mc_xfer;
   logic              mc_refused;
   logic              issue_eff;
   logic              mc_issue;
   logic              set_en;
   logic [31:0]       set_mask;
   logic [31:0]       clr_mask;

   always_comb begin
      wb_eff        = wb_valid & (wb_rd != 5'd0);
      mc_ready      = ~reset & ~wb_eff;

      rf_wen        = 1'b0;
      rf_write_reg  = 5'd0;
      rf_write_data = 32'd0;
      if (!reset) begin
         if (wb_eff) begin
            rf_wen        = 1'b1;
            rf_write_reg  = wb_rd;
            rf_write_data = wb_data;
         end else if (mc_valid && (mc_rd != 5'd0)) begin
            rf_wen        = 1'b1;
            rf_write_reg  = mc_rd;
            rf_write_data = mc_data;
         end
      end

      // A result clearing busy this cycle does not release the stall until
      // the register update is visible next cycle (no same-cycle bypass).
      issue_stall = ~reset & id_valid &
                    (busy[id_rs1] | busy[id_rs2] | (id_rd_wen & busy[id_rd]) |
                     starve | (id_is_mc & (outstanding == OUT_MAX)));

      busy_vec    = reset ? 32'd0 : busy;

      mc_xfer     = mc_valid & mc_ready;
      mc_refused  = mc_valid & ~mc_ready;
      issue_eff   = id_valid & ~issue_stall;
      mc_issue    = issue_eff & id_is_mc;
      set_en      = mc_issue & id_rd_wen & (id_rd != 5'd0);
      set_mask    = set_en  ? (32'd1 << id_rd) : 32'd0;
      clr_mask    = mc_xfer ? (32'd1 << mc_rd) : 32'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy        <= 32'd0;
         outstanding <= '0;
         wait_rem    <= WAIT_LOAD;
         starve      <= 1'b0;
      end else begin
         busy <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;

         case ({mc_issue, mc_xfer})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
            default: ;
         endcase

         // Budget reloads whenever the MC result is not being refused.
         if (mc_refused) begin
            if (wait_rem != '0) wait_rem <= wait_rem - 1'b1;
         end else begin
            wait_rem <= WAIT_LOAD;
         end

         // Starvation asserts on the refusal that exhausts the budget and
         // holds until the waiting result finally transfers.
         starve <= (starve | (mc_refused & (wait_rem == WAIT_LAST))) & ~mc_xfer;

         a_no_set_clr_same_reg:
            assert (!(set_en && mc_xfer && (id_rd == mc_rd)));
         a_no_outstanding_underflow:
            assert (!(mc_xfer && (outstanding == '0)));
      end
   end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
module tb_regfile_wb_scoreboard;

   localparam int MAX_OUT  = 4;
   localparam int MAX_WAIT = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid, id_rd_wen, id_is_mc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        issue_stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic [4:0]  mc_rd;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        rf_wen;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;
   logic [31:0] busy_vec;

   always #5 clock = ~clock;

   regfile_wb_scoreboard #(
      .MAX_OUTSTANDING (MAX_OUT),
      .MAX_WAIT        (MAX_WAIT)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rd         (id_rd),
      .id_rd_wen     (id_rd_wen),
      .id_is_mc      (id_is_mc),
      .issue_stall   (issue_stall),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .mc_valid      (mc_valid),
      .mc_rd         (mc_rd),
      .mc_data       (mc_data),
      .mc_ready      (mc_ready),
      .rf_wen        (rf_wen),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .busy_vec      (busy_vec)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the list of MC ops in flight (destination, 0 if none),
   // plus the starvation bookkeeping.
   int   inflight[$];
   int   wait_m;
   bit   starve_m;

   // MC unit stand-in: a presented result stays up until it transfers.
   bit          hold;
   logic [4:0]  hold_rd;
   logic [31:0] hold_data;

   logic        e_wen, e_ready, e_stall;
   logic [4:0]  e_reg;
   logic [31:0] e_data, e_busy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%08h expected=%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_busy(input int r);
      if (r == 0) return 1'b0;
      foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] v = 32'd0;
      for (int r = 1; r < 32; r++) if (is_busy(r)) v[r] = 1'b1;
      return v;
   endfunction

   // Inputs are already applied (at the negedge). Check outputs, then apply
   // the posedge to the model.
   task automatic cycle();
      bit wb_eff, xfer, refused, issue;
      int idx;
      #1;
      wb_eff  = wb_valid && (wb_rd != 5'd0);
      e_ready = !reset && !wb_eff;
      e_wen   = 1'b0;
      e_reg   = 5'd0;
      e_data  = 32'd0;
      if (!reset && wb_eff) begin
         e_wen = 1'b1; e_reg = wb_rd; e_data = wb_data;
      end else if (!reset && mc_valid && mc_rd != 5'd0) begin
         e_wen = 1'b1; e_reg = mc_rd; e_data = mc_data;
      end
      e_stall = !reset && id_valid &&
                (is_busy(id_rs1) || is_busy(id_rs2) || (id_rd_wen && is_busy(id_rd)) ||
                 starve_m || (id_is_mc && inflight.size() == MAX_OUT));
      e_busy  = reset ? 32'd0 : model_busy();

      chk("rf_wen",        rf_wen,        e_wen);
      chk("rf_write_reg",  rf_write_reg,  e_reg);
      chk("rf_write_data", rf_write_data, e_data);
      chk("mc_ready",      mc_ready,      e_ready);
      chk("issue_stall",   issue_stall,   e_stall);
      chk("busy_vec",      busy_vec,      e_busy);

      @(posedge clock);
      if (reset) begin
         inflight.delete();
         wait_m   = 0;
         starve_m = 1'b0;
         hold     = 1'b0;
      end else begin
         xfer    = mc_valid && e_ready;
         refused = mc_valid && !e_ready;
         issue   = id_valid && !e_stall;
         if (xfer) begin
            idx = -1;
            foreach (inflight[i]) if (idx < 0 && inflight[i] == int'(mc_rd)) idx = i;
            chk("model_result_known", (idx >= 0), 1'b1);
            if (idx >= 0) inflight.delete(idx);
            hold = 1'b0;
         end
         if (issue && id_is_mc) inflight.push_back(id_rd_wen ? int'(id_rd) : 0);
         if (refused) wait_m = (wait_m < MAX_WAIT) ? wait_m + 1 : MAX_WAIT;
         else         wait_m = 0;
         starve_m = (starve_m || (refused && wait_m == MAX_WAIT)) && !xfer;
      end
      @(negedge clock);
   endtask

   task automatic drive_random(input int wb_pct, input bit wb_rd_nonzero);
      int idx;
      reset     = ($urandom_range(0, 199) == 0);
      id_valid  = ($urandom_range(0, 99) < 70);
      id_rs1    = 5'($urandom_range(0, 7));
      id_rs2    = 5'($urandom_range(0, 7));
      id_rd     = 5'($urandom_range(0, 11));
      id_rd_wen = ($urandom_range(0, 99) < 85);
      id_is_mc  = ($urandom_range(0, 99) < 35);
      wb_valid  = ($urandom_range(0, 99) < wb_pct);
      wb_rd     = wb_rd_nonzero ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      if (!hold && !reset && inflight.size() > 0 && $urandom_range(0, 99) < 50) begin
         idx       = $urandom_range(0, inflight.size() - 1);
         hold      = 1'b1;
         hold_rd   = 5'(inflight[idx]);
         hold_data = $urandom;
      end
      mc_valid = hold && !reset;
      mc_rd    = hold ? hold_rd : 5'($urandom_range(0, 31));
      mc_data  = hold ? hold_data : $urandom;
   endtask

   initial begin
      wait_m = 0; starve_m = 1'b0; hold = 1'b0;
      hold_rd = 5'd0; hold_data = 32'd0;
      reset = 1'b1;
      id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
      id_rd_wen = 1'b0; id_is_mc = 1'b0;
      wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      mc_valid = 1'b0; mc_rd = 5'd0; mc_data = 32'd0;

      @(negedge clock);
      cycle();
      cycle();
      reset = 1'b0;

      // MC issue to x5, then dependent add x6,x5,x3 held in decode.
      id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd5;
      id_rd_wen = 1'b1; id_is_mc = 1'b1;
      cycle();
      #1 chk("tp_busy_x5", busy_vec, 32'h0000_0020);
      id_rs1 = 5'd5; id_rs2 = 5'd3; id_rd = 5'd6; id_is_mc = 1'b0;
      #1 chk("tp_raw_stall", issue_stall, 1'b1);
      repeat (2) cycle();

      // WB to x7 collides with the x5 result: WB wins.
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_1234;
      mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'hCAFE_0005;
      #1;
      chk("tp_wb_wins_reg",  rf_write_reg,  32'd7);
      chk("tp_wb_wins_data", rf_write_data, 32'h0000_1234);
      chk("tp_wb_wins_rdy",  mc_ready,      1'b0);
      cycle();
      wb_valid = 1'b0;
      #1;
      chk("tp_mc_reg",       rf_write_reg, 32'd5);
      chk("tp_mc_ready",     mc_ready,     1'b1);
      chk("tp_no_bypass",    issue_stall,  1'b1);
      cycle();
      mc_valid = 1'b0;
      #1 chk("tp_stall_release", issue_stall, 1'b0);
      chk("tp_busy_clear", busy_vec, 32'd0);
      cycle();

      // MC op without a destination, then its result to x0 against WB to x0.
      id_is_mc = 1'b1; id_rd_wen = 1'b0; id_rd = 5'd9;
      cycle();
      id_valid = 1'b0; id_is_mc = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1111_2222;
      mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h3333_4444;
      #1;
      chk("tp_x0_ready", mc_ready, 1'b1);
      chk("tp_x0_wen",   rf_wen,   1'b0);
      cycle();
      wb_valid = 1'b0; mc_valid = 1'b0;
      cycle();

      // Randomized phases: light WB, heavy WB, near-saturated WB (starvation), idle WB.
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 300; c++) begin
            case (p)
               0: drive_random(30, 1'b0);
               1: drive_random(70, 1'b0);
               2: drive_random(93, 1'b1);
               default: drive_random(0, 1'b0);
            endcase
            cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
